ps2_ctrl: RTL and testbench
===========================

Name: ps2_ctrl

Overview:
- Sequencing controller for the PS/2 RX/TX datapath block.
- Owns the bus-direction decision and generates the datapath's mode strobes (state_receive, state_transmit) and the host line overrides (ps2_clk_out, ps2_data_out1).
- Runs the host-to-device protocol: clock inhibit, request-to-send, start bit, transmit, device ACK, timeout and abort.
- Sits between the wishbone CSR decode and the datapath; a CPU write to the TX register triggers a transmit, otherwise the bus stays in receive.

Parameters:
- INHIBIT_CYCLES, 5000: sys_clk cycles ps2_clk is held low before request (100 us at 50 MHz).
- REQ_CYCLES, 8: cycles clock and data are both held low before the clock is released.
- TIMEOUT_CYCLES, 750000: maximum cycles from clock release to device ACK (15 ms).
- CNT_W, 20: width of the shared down-counter; must hold the largest cycle parameter.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  synchronous reset, active-low.
- we_reg  input  1  one-cycle pulse from the datapath: TX byte latched.
- rx_bitcount  input  5  datapath bit counter.
- rx_avail  input  1  datapath pulse: RX byte complete.
- ps2_clk_2  input  1  synchronized PS/2 clock from the datapath.
- ps2_data_in  input  1  synchronized PS/2 data.
- state_receive  output  1  enables datapath RX shifting.
- state_transmit  output  1  enables datapath TX shifting.
- ps2_clk_out  output  1  0 = pull PS/2 clock low, 1 = release.
- ps2_data_out1  output  1  0 = pull PS/2 data low, 1 = release.
- busy  output  1  high in any state other than IDLE.
- tx_done  output  1  one-cycle pulse: device ACK received.
- tx_err  output  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Reset (sys_rst==0 at a sys_clk edge):
  - State goes to IDLE; counter and pending are cleared.
  - Outputs: state_receive=1, state_transmit=0, ps2_clk_out=1, ps2_data_out1=1, busy=0, tx_done=0, tx_err=0.
  - Reset mid-transfer releases both lines on the next edge; no done or error pulse is issued.
- Clock edge detect: clk_q registers ps2_clk_2; a fall is clk_q==1 && ps2_clk_2==0.
- pending flag:
  - Set by we_reg in any state.
  - Cleared on entry to INHIBIT.
  - A second we_reg while pending is already set is absorbed; the datapath holds only one byte.
- All outputs are registered and change one cycle after the state decision.

States:
- IDLE: receive mode (state_receive=1, both lines released).
  - If pending && rx_bitcount==0 → INHIBIT, counter=INHIBIT_CYCLES-1.
  - A request arriving mid-receive waits until the datapath counter returns to 0, i.e. after rx_avail or the idle reset.
- INHIBIT: ps2_clk_out=0, state_receive=0, state_transmit=0. Counter decrements; at 0 → REQ, counter=REQ_CYCLES-1.
- REQ: ps2_clk_out=0, ps2_data_out1=0. At counter 0 → START, counter=TIMEOUT_CYCLES-1.
- START: ps2_clk_out=1, ps2_data_out1=0 (start bit), state_transmit=1. On the first clock fall → TRANSMIT with ps2_data_out1=1, so the datapath drives bits from here.
- TRANSMIT: state_transmit=1. When rx_bitcount==11 (8 data bits, parity and stop have been driven) → ACK.
- ACK: state_transmit=0, lines released.
  - If ps2_data_in==0 && ps2_clk_2==0 → tx_done pulse, then WAIT_IDLE.
  - If a rising clock edge occurs with data still high → tx_err pulse, then ABORT.
- WAIT_IDLE: when ps2_clk_2==1 && ps2_data_in==1 → IDLE.
- ABORT: ps2_clk_out=0 for INHIBIT_CYCLES, then IDLE; this forces the device and the datapath counter to resynchronize.
- Timeout: the counter runs continuously through START, TRANSMIT and ACK. Reaching 0 in any of those states → tx_err pulse, then ABORT. Timeout takes priority over a same-cycle ACK.
- rx_avail has no effect outside IDLE.

Test Plan:
- Reset: hold sys_rst=0 for 3 cycles, release → all outputs at their reset values, busy=0, lines released.
- Normal TX of 0xF4 with a device model (≈12.8 kHz clock, ACK on 11th clock) → clock low for 5000 cycles, data low before clock release, 11 falls observed, tx_done pulses once, then busy=0.
- Device never clocks after request → tx_err pulses exactly 750000 cycles after START entry, clock is held low for 5000 cycles, then IDLE.
- Device completes 11 clocks but no ACK (data high on ACK clock) → tx_err, ABORT, no tx_done.
- we_reg while rx_bitcount=5 during a receive → INHIBIT is not entered until rx_avail and rx_bitcount==0, then the TX of 0xFF completes with tx_done.
- Assert sys_rst=0 during TRANSMIT at bit 4 → next edge releases both lines, state_transmit=0; no tx_done or tx_err.

Source files
------------

// File: rtl/ps2_ctrl.sv
// PS/2 host sequencing controller: owns bus direction, runs the host-to-device
// request/transmit/ACK handshake and drives the host line overrides.
module ps2_ctrl #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned REQ_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       we_reg,
  input  logic [4:0] rx_bitcount,
  input  logic       rx_avail,
  input  logic       ps2_clk_2,
  input  logic       ps2_data_in,
  output logic       state_receive,
  output logic       state_transmit,
  output logic       ps2_clk_out,
  output logic       ps2_data_out1,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_START,
    S_TRANSMIT,
    S_ACK,
    S_WAIT_IDLE,
    S_ABORT
  } state_e;

  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LOAD     = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]       LAST_BIT     = 5'd11;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             pending_q, pending_d;
  logic             clk_q;
  logic             cnt_zero, clk_fall, clk_rise;
  logic             tx_done_d, tx_err_d;
  logic             recv_d, trans_d, clk_out_d, data_out_d, busy_d;

  assign cnt_dec  = cnt_q - CNT_W'(1);
  assign cnt_zero = (cnt_q == '0);
  assign clk_fall = clk_q & ~ps2_clk_2;
  assign clk_rise = ~clk_q & ps2_clk_2;

  // Next-state, counter and pending decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | we_reg;
    tx_done_d = 1'b0;
    tx_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Hold off while the datapath is still finishing a received byte.
        if (pending_q && (rx_bitcount == 5'd0) && !rx_avail) begin
          state_d   = S_INHIBIT;
          cnt_d     = INHIBIT_LOAD;
          pending_d = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (cnt_zero) begin
          state_d = S_REQ;
          cnt_d   = REQ_LOAD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_REQ: begin
        if (cnt_zero) begin
          state_d = S_START;
          cnt_d   = TIMEOUT_LOAD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_START, S_TRANSMIT, S_ACK: begin
        cnt_d = cnt_dec;
        if (cnt_zero) begin
          tx_err_d = 1'b1;
          state_d  = S_ABORT;
          cnt_d    = INHIBIT_LOAD;
        end else if (state_q == S_START) begin
          if (clk_fall) state_d = S_TRANSMIT;
        end else if (state_q == S_TRANSMIT) begin
          if (rx_bitcount == LAST_BIT) state_d = S_ACK;
        end else if (!ps2_data_in && !ps2_clk_2) begin
          tx_done_d = 1'b1;
          state_d   = S_WAIT_IDLE;
        end else if (clk_rise && ps2_data_in) begin
          tx_err_d = 1'b1;
          state_d  = S_ABORT;
          cnt_d    = INHIBIT_LOAD;
        end
      end
      S_WAIT_IDLE: begin
        if (ps2_clk_2 && ps2_data_in) state_d = S_IDLE;
      end
      S_ABORT: begin
        if (cnt_zero) state_d = S_IDLE;
        else          cnt_d   = cnt_dec;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line and mode outputs decoded from the upcoming state, then registered.
  always_comb begin
    recv_d     = (state_d == S_IDLE);
    trans_d    = (state_d == S_START) || (state_d == S_TRANSMIT);
    clk_out_d  = !((state_d == S_INHIBIT) || (state_d == S_REQ) || (state_d == S_ABORT));
    data_out_d = !((state_d == S_REQ) || (state_d == S_START));
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      clk_q          <= 1'b1;
      state_receive  <= 1'b1;
      state_transmit <= 1'b0;
      ps2_clk_out    <= 1'b1;
      ps2_data_out1  <= 1'b1;
      busy           <= 1'b0;
      tx_done        <= 1'b0;
      tx_err         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      clk_q          <= ps2_clk_2;
      state_receive  <= recv_d;
      state_transmit <= trans_d;
      ps2_clk_out    <= clk_out_d;
      ps2_data_out1  <= data_out_d;
      busy           <= busy_d;
      tx_done        <= tx_done_d;
      tx_err         <= tx_err_d;
    end
  end

endmodule

// File: tb/tb_ps2_ctrl.sv
// Directed bench for ps2_ctrl: vector table for reset/IDLE gating plus
// hand-written transmit, timeout, missing-ACK and mid-transfer reset sequences.
module tb_ps2_ctrl;

  localparam int unsigned INH = 20;
  localparam int unsigned REQ = 4;
  localparam int unsigned TMO = 400;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       we_reg;
  logic [4:0] rx_bitcount;
  logic       rx_avail;
  logic       ps2_clk_2;
  logic       ps2_data_in;
  logic       state_receive, state_transmit, ps2_clk_out, ps2_data_out1;
  logic       busy, tx_done, tx_err;
  logic [6:0] outs;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_err = 0;

  ps2_ctrl #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES(REQ),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(20)
  ) dut (
    .sys_clk(clk),
    .sys_rst(sys_rst),
    .we_reg(we_reg),
    .rx_bitcount(rx_bitcount),
    .rx_avail(rx_avail),
    .ps2_clk_2(ps2_clk_2),
    .ps2_data_in(ps2_data_in),
    .state_receive(state_receive),
    .state_transmit(state_transmit),
    .ps2_clk_out(ps2_clk_out),
    .ps2_data_out1(ps2_data_out1),
    .busy(busy),
    .tx_done(tx_done),
    .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  assign outs = {busy, state_receive, state_transmit, ps2_clk_out, ps2_data_out1, tx_done, tx_err};

  // {busy, recv, trans, clk_out, data_out, done, err}
  localparam logic [6:0] O_IDLE = 7'b0101100;
  localparam logic [6:0] O_INH  = 7'b1000100;

  typedef struct {
    logic       rst;
    logic       we;
    logic [4:0] bc;
    logic       av;
    logic [6:0] exp;
  } vec_t;

  vec_t vt[15];

  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_done) n_done++;
    if (tx_err) n_err++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // CPU write, then measure the inhibit and request-to-send phases.
  task automatic request_phase(input string tag);
    int n;
    rx_bitcount = 5'd0;
    we_reg = 1'b1;
    tick();
    we_reg = 1'b0;
    tick();
    check({tag, "_inh_entry"}, 32'({ps2_clk_out, ps2_data_out1, busy}), 32'b011);
    n = 0;
    while (!ps2_clk_out && ps2_data_out1 && n < 100) begin
      n++;
      tick();
    end
    check({tag, "_inh_len"}, 32'(n), 32'(INH));
    n = 0;
    while (!ps2_clk_out && !ps2_data_out1 && n < 100) begin
      n++;
      tick();
    end
    check({tag, "_req_len"}, 32'(n), 32'(REQ));
    check({tag, "_start"}, 32'({ps2_clk_out, ps2_data_out1, state_transmit, state_receive}), 32'b1010);
  endtask

  // Device clock pulses; the datapath bit counter follows each fall.
  task automatic dev_clocks(input int n);
    for (int i = 1; i <= n; i++) begin
      ps2_clk_2 = 1'b0;
      rx_bitcount = 5'(i);
      repeat (5) tick();
      ps2_clk_2 = 1'b1;
      repeat (5) tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, k;
    vt[0]  = '{1'b0, 1'b0, 5'd0, 1'b0, O_IDLE};
    vt[1]  = '{1'b0, 1'b0, 5'd0, 1'b0, O_IDLE};
    vt[2]  = '{1'b1, 1'b0, 5'd0, 1'b0, O_IDLE};
    vt[3]  = '{1'b1, 1'b1, 5'd5, 1'b0, O_IDLE};
    vt[4]  = '{1'b1, 1'b0, 5'd5, 1'b0, O_IDLE};
    vt[5]  = '{1'b1, 1'b0, 5'd5, 1'b0, O_IDLE};
    vt[6]  = '{1'b1, 1'b0, 5'd0, 1'b1, O_IDLE};
    vt[7]  = '{1'b1, 1'b0, 5'd0, 1'b0, O_INH};
    vt[8]  = '{1'b1, 1'b0, 5'd0, 1'b0, O_INH};
    vt[9]  = '{1'b0, 1'b0, 5'd0, 1'b0, O_IDLE};
    vt[10] = '{1'b1, 1'b1, 5'd0, 1'b0, O_IDLE};
    vt[11] = '{1'b1, 1'b0, 5'd0, 1'b0, O_INH};
    vt[12] = '{1'b0, 1'b0, 5'd0, 1'b0, O_IDLE};
    vt[13] = '{1'b1, 1'b0, 5'd0, 1'b0, O_IDLE};
    vt[14] = '{1'b1, 1'b0, 5'd0, 1'b0, O_IDLE};

    sys_rst = 1'b0;
    we_reg = 1'b0;
    rx_bitcount = 5'd0;
    rx_avail = 1'b0;
    ps2_clk_2 = 1'b1;
    ps2_data_in = 1'b1;

    for (int i = 0; i < 15; i++) begin
      sys_rst = vt[i].rst;
      we_reg = vt[i].we;
      rx_bitcount = vt[i].bc;
      rx_avail = vt[i].av;
      tick();
      check($sformatf("vec%0d", i), 32'(outs), 32'(vt[i].exp));
    end
    we_reg = 1'b0;
    rx_avail = 1'b0;

    // Normal transmit with device ACK on the 11th clock.
    d0 = n_done;
    e0 = n_err;
    request_phase("tx");
    dev_clocks(10);
    check("tx_transmit", 32'({ps2_clk_out, ps2_data_out1, state_transmit}), 32'b111);
    ps2_data_in = 1'b0;
    tick();
    ps2_clk_2 = 1'b0;
    rx_bitcount = 5'd11;
    repeat (5) tick();
    ps2_clk_2 = 1'b1;
    repeat (5) tick();
    ps2_data_in = 1'b1;
    rx_bitcount = 5'd0;
    repeat (3) tick();
    check("tx_done_cnt", 32'(n_done - d0), 32'd1);
    check("tx_err_cnt", 32'(n_err - e0), 32'd0);
    check("tx_idle", 32'(outs), 32'(O_IDLE));

    // Device never clocks: timeout from START entry, then abort.
    d0 = n_done;
    e0 = n_err;
    request_phase("tmo");
    k = 0;
    while (!tx_err && k < 1000) begin
      tick();
      k++;
    end
    check("tmo_latency", 32'(k), 32'(TMO));
    k = 0;
    while (!ps2_clk_out && k < 100) begin
      k++;
      tick();
    end
    check("tmo_abort_len", 32'(k), 32'(INH));
    check("tmo_idle", 32'(outs), 32'(O_IDLE));
    check("tmo_err_cnt", 32'(n_err - e0), 32'd1);
    check("tmo_done_cnt", 32'(n_done - d0), 32'd0);

    // Eleven clocks but data stays high on the ACK clock.
    d0 = n_done;
    e0 = n_err;
    request_phase("nak");
    dev_clocks(10);
    ps2_clk_2 = 1'b0;
    rx_bitcount = 5'd11;
    repeat (5) tick();
    ps2_clk_2 = 1'b1;
    tick();
    check("nak_err_pulse", 32'({tx_err, ps2_clk_out}), 32'b10);
    rx_bitcount = 5'd0;
    k = 0;
    while (!ps2_clk_out && k < 100) begin
      k++;
      tick();
    end
    check("nak_abort_len", 32'(k), 32'(INH));
    check("nak_err_cnt", 32'(n_err - e0), 32'd1);
    check("nak_done_cnt", 32'(n_done - d0), 32'd0);
    check("nak_idle", 32'(busy), 32'd0);

    // Reset while transmitting bit 4.
    d0 = n_done;
    e0 = n_err;
    request_phase("rst");
    dev_clocks(4);
    check("rst_in_tx", 32'(state_transmit), 32'd1);
    sys_rst = 1'b0;
    tick();
    check("rst_release", 32'(outs), 32'(O_IDLE));
    sys_rst = 1'b1;
    rx_bitcount = 5'd0;
    repeat (5) tick();
    check("rst_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);
    check("rst_idle", 32'(outs), 32'(O_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
